// File: rtl/m_extension_unit_if.sv
// Handshake and data bundle between the core and the iterative RV32M unit.
// The core drives the request side (master); the unit answers with busy/done/result (slave).
interface m_extension_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic            flush;
  logic [4:0]      alu_function;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start,
    output flush,
    output alu_function,
    output operand_a,
    output operand_b,
    input  busy,
    input  done,
    input  result
  );

  modport slave (
    input  start,
    input  flush,
    input  alu_function,
    input  operand_a,
    input  operand_b,
    output busy,
    output done,
    output result
  );
endinterface

// File: rtl/m_extension_unit.sv
// Iterative RV32M unit: radix-2 shift-add multiply and restoring divide on operand magnitudes,
// one bit per cycle, with sign fix-up and divide special cases applied in the FINISH cycle.
module m_extension_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CYCLES = 32
) (
  input logic              clock,
  input logic              reset_n,
  m_extension_unit_if.slave bus
);

  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;

  localparam int unsigned CntW = $clog2(CYCLES);

  typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

  state_e state_q, state_d;

  logic [4:0]        func_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_mag_q;
  logic              a_neg_q;
  logic              b_neg_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CntW-1:0]   counter_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  logic accept;
  logic last_iter;

  assign accept    = (state_q == StIdle) && bus.start && !bus.flush;
  assign last_iter = (counter_q == CntW'(CYCLES - 1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (accept) state_d = StCalc;
      StCalc: begin
        if (bus.flush)      state_d = StIdle;
        else if (last_iter) state_d = StFinish;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == StCalc) || (state_q == StFinish);
  end

  assign bus.done   = done_q;
  assign bus.result = result_q;

  // ---------------------------------------------------------------------------
  // Operand decode at accept time
  // ---------------------------------------------------------------------------
  logic            in_a_signed;
  logic            in_b_signed;
  logic            in_a_neg;
  logic            in_b_neg;
  logic [XLEN-1:0] in_a_mag;
  logic [XLEN-1:0] in_b_mag;

  always_comb begin
    in_a_signed = (bus.alu_function == ALU_MUL)    || (bus.alu_function == ALU_MULH) ||
                  (bus.alu_function == ALU_MULHSU) || (bus.alu_function == ALU_DIV)  ||
                  (bus.alu_function == ALU_REM);
    in_b_signed = (bus.alu_function == ALU_MUL) || (bus.alu_function == ALU_MULH) ||
                  (bus.alu_function == ALU_DIV) || (bus.alu_function == ALU_REM);
    in_a_neg    = in_a_signed && bus.operand_a[XLEN-1];
    in_b_neg    = in_b_signed && bus.operand_b[XLEN-1];
    in_a_mag    = in_a_neg ? -bus.operand_a : bus.operand_a;
    in_b_mag    = in_b_neg ? -bus.operand_b : bus.operand_b;
  end

  // ---------------------------------------------------------------------------
  // One iteration of multiply or divide
  // ---------------------------------------------------------------------------
  logic              is_div;
  logic [XLEN-1:0]   mul_addend;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_hi;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    is_div     = (func_q == ALU_DIV) || (func_q == ALU_DIVU) ||
                 (func_q == ALU_REM) || (func_q == ALU_REMU);
    // Multiply: {hi, lo} with lo holding the shifting multiplier magnitude.
    mul_addend = acc_q[0] ? b_mag_q : {XLEN{1'b0}};
    mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
    mul_next   = {mul_sum, acc_q[XLEN-1:1]};
    // Divide: {rem, quo}; shifted remainder may need XLEN+1 bits before the trial subtract.
    div_hi     = acc_q[2*XLEN-1:XLEN-1];
    div_ge     = (div_hi >= {1'b0, b_mag_q});
    div_diff   = div_hi[XLEN-1:0] - b_mag_q;
    div_next   = {(div_ge ? div_diff : div_hi[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
  end

  // ---------------------------------------------------------------------------
  // Sign fix-up and special cases
  // ---------------------------------------------------------------------------
  logic              sign_diff;
  logic              b_zero;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   result_fix;

  always_comb begin
    sign_diff = a_neg_q ^ b_neg_q;
    b_zero    = (b_mag_q == {XLEN{1'b0}});
    prod      = sign_diff ? -acc_q : acc_q;
    quo       = acc_q[XLEN-1:0];
    rem       = acc_q[2*XLEN-1:XLEN];
    result_fix = {XLEN{1'b0}};
    case (func_q)
      ALU_MUL:    result_fix = prod[XLEN-1:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  result_fix = prod[2*XLEN-1:XLEN];
      ALU_DIV:    result_fix = b_zero ? {XLEN{1'b1}} : (sign_diff ? -quo : quo);
      ALU_DIVU:   result_fix = b_zero ? {XLEN{1'b1}} : quo;
      ALU_REM:    result_fix = b_zero ? a_q : (a_neg_q ? -rem : rem);
      ALU_REMU:   result_fix = b_zero ? a_q : rem;
      default:    result_fix = {XLEN{1'b0}};
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      func_q    <= 5'd0;
      a_q       <= {XLEN{1'b0}};
      b_mag_q   <= {XLEN{1'b0}};
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      acc_q     <= {2*XLEN{1'b0}};
      counter_q <= {CntW{1'b0}};
      done_q    <= 1'b0;
      result_q  <= {XLEN{1'b0}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            func_q    <= bus.alu_function;
            a_q       <= bus.operand_a;
            b_mag_q   <= in_b_mag;
            a_neg_q   <= in_a_neg;
            b_neg_q   <= in_b_neg;
            acc_q     <= {{XLEN{1'b0}}, in_a_mag};
            counter_q <= {CntW{1'b0}};
          end
        end
        StCalc: begin
          if (!bus.flush) begin
            acc_q     <= is_div ? div_next : mul_next;
            counter_q <= counter_q + 1'b1;
          end
        end
        StFinish: begin
          if (!bus.flush) begin
            result_q <= result_fix;
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_m_extension_unit.sv
// Self-checking bench for m_extension_unit: directed RV32M cases, randomized operations against
// an arithmetic reference model, and start/flush/reset interference during an operation.
module tb_m_extension_unit;

  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;

  logic        clock = 1'b0;
  logic        reset_n;
  int          tests  = 0;
  int          failed = 0;
  logic [31:0] last_result;

  m_extension_unit_if #(.XLEN(32)) bus ();

  m_extension_unit #(.XLEN(32), .CYCLES(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the RV32M arithmetic definitions.
  function automatic logic [31:0] ref_model(input logic [4:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f)
      ALU_MUL:    begin p = sa * sb; return p[31:0];  end
      ALU_MULH:   begin p = sa * sb; return p[63:32]; end
      ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
      ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
      ALU_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      ALU_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      ALU_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      ALU_REMU: return (b == 32'd0) ? a : a % b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, optionally poke a second start at cycle inject_at, then observe 74 cycles.
  task automatic run_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag, input int inject_at);
    int          first_done = 0;
    int          busy_cnt   = 0;
    int          done_cnt   = 0;
    logic [31:0] res        = 'x;
    @(negedge clock);
    bus.start        = 1'b1;
    bus.alu_function = f;
    bus.operand_a    = a;
    bus.operand_b    = b;
    for (int i = 1; i <= 74; i++) begin
      @(negedge clock);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (first_done == 0) begin
          first_done = i;
          res        = bus.result;
        end
      end
      if (i == 1) begin
        bus.start        = 1'b0;
        bus.operand_a    = $urandom;
        bus.operand_b    = $urandom;
        bus.alu_function = 5'($urandom);
      end
      if (i == inject_at) begin
        bus.start        = 1'b1;
        bus.alu_function = ALU_DIVU;
        bus.operand_a    = $urandom;
        bus.operand_b    = 32'd3;
      end
      if (i == inject_at + 1) bus.start = 1'b0;
    end
    check($sformatf("%s result", tag), 64'(res), 64'(exp));
    check($sformatf("%s latency", tag), 64'(first_done), 64'd34);
    check($sformatf("%s busy_cycles", tag), 64'(busy_cnt), 64'd33);
    check($sformatf("%s done_count", tag), 64'(done_cnt), 64'd1);
    last_result = exp;
  endtask

  task automatic flush_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input string tag);
    int done_cnt = 0;
    @(negedge clock);
    bus.start        = 1'b1;
    bus.alu_function = f;
    bus.operand_a    = a;
    bus.operand_b    = b;
    for (int i = 1; i <= flush_at; i++) begin
      @(negedge clock);
      if (bus.done) done_cnt++;
      if (i == 1) bus.start = 1'b0;
    end
    bus.flush = 1'b1;
    bus.start = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    bus.start = 1'b0;
    check($sformatf("%s busy_after_flush", tag), 64'(bus.busy), 64'd0);
    check($sformatf("%s result_kept", tag), 64'(bus.result), 64'(last_result));
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.done) done_cnt++;
    end
    check($sformatf("%s no_done", tag), 64'(done_cnt), 64'd0);
    check($sformatf("%s result_still_kept", tag), 64'(bus.result), 64'(last_result));
  endtask

  task automatic reset_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    int done_cnt = 0;
    @(negedge clock);
    bus.start        = 1'b1;
    bus.alu_function = f;
    bus.operand_a    = a;
    bus.operand_b    = b;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (i == 1) bus.start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check("midop_reset busy", 64'(bus.busy), 64'd0);
    check("midop_reset done", 64'(bus.done), 64'd0);
    check("midop_reset result", 64'(bus.result), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.done) done_cnt++;
    end
    check("midop_reset no_done", 64'(done_cnt), 64'd0);
    last_result = 32'd0;
  endtask

  initial begin
    logic [4:0]  f;
    logic [31:0] a, b;

    bus.start        = 1'b0;
    bus.flush        = 1'b0;
    bus.alu_function = 5'd0;
    bus.operand_a    = 32'd0;
    bus.operand_b    = 32'd0;
    reset_n          = 1'b0;
    last_result      = 32'd0;
    repeat (3) @(negedge clock);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset result", 64'(bus.result), 64'd0);
    reset_n = 1'b1;

    run_op(ALU_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul", 0);
    run_op(ALU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh", 0);
    run_op(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu", 0);
    run_op(ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu", 0);
    run_op(ALU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_neg", 0);
    run_op(ALU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_neg", 0);
    run_op(ALU_DIVU,   32'd100,       32'd7,         32'd14,        "divu", 0);
    run_op(ALU_REMU,   32'd100,       32'd7,         32'd2,         "remu", 0);
    run_op(ALU_DIVU,   32'h1234_5678, 32'd0,         32'hFFFF_FFFF, "divu_by_zero", 0);
    run_op(ALU_REMU,   32'h1234_5678, 32'd0,         32'h1234_5678, "remu_by_zero", 0);
    run_op(ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow", 0);
    run_op(ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_overflow", 0);
    run_op(5'd3,       32'h1234_5678, 32'h9ABC_DEF0, 32'd0,         "non_m_code", 0);

    run_op(ALU_MUL,   32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "start_while_busy", 10);
    run_op(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "start_in_finish", 33);

    run_op(ALU_DIVU, 32'd100, 32'd7, 32'd14, "pre_flush", 0);
    flush_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 15, "flush_calc");
    run_op(ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "after_flush", 0);
    flush_op(ALU_MUL, 32'd5, 32'd6, 33, "flush_finish");

    reset_op(ALU_DIV, 32'd1000, 32'd3);
    run_op(ALU_MUL, 32'd12345, 32'd678, 32'd8369910, "after_reset", 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 8) f = 5'd16 + 5'($urandom_range(0, 7));
      else                          f = 5'($urandom_range(0, 15));
      a = pick_operand();
      b = pick_operand();
      run_op(f, a, b, ref_model(f, a, b), $sformatf("rand f=%0d a=%h b=%h", f, a, b), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/m_extension_unit.md
Name: m_extension_unit

Overview:
- Iterative execution unit for the RV32M operations selected by `alu_function` (`ALU_MUL`, `ALU_MULH`, `ALU_MULHSU`, `ALU_MULHU`, `ALU_DIV`, `ALU_DIVU`, `ALU_REM`, `ALU_REMU`).
- Consumer end of the ALU-control interface when M_MODULE is defined.
- Implements radix-2 shift-add multiply and restoring divide on operand magnitudes, with sign fix-up at the end.
- Core stalls on `busy` and captures `result` on `done`.

Parameters:
- XLEN, 32, operand and result width. Only 32 is supported.
- CYCLES, 32, iteration count; equals XLEN.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- flush  input  1  abort the current operation; no `done` is produced.
- alu_function  input  5  operation code, latched on accept.
- operand_a  input  XLEN  rs1 value, latched on accept.
- operand_b  input  XLEN  rs2 value, latched on accept.
- busy  output  1  high in CALC and FINISH.
- done  output  1  one-cycle pulse when `result` is valid.
- result  output  XLEN  registered result; holds until the next `done`.

Behaviour:
- Reset (async, `reset_n`=0): state=IDLE, busy=0, done=0, result=0, counter=0, all internal registers 0.
- IDLE:
  - On `start`=1 and `flush`=0: latch function, operands, sign flags and magnitudes; counter=0; go to CALC.
  - `done` is cleared in IDLE unless it is being pulsed.
- CALC: one iteration per cycle, counter increments.
  - Multiply: 64-bit accumulator adds the multiplicand magnitude when the current multiplier LSB is 1, then shifts.
  - Divide: 64-bit remainder/quotient register shifts left; trial-subtract the divisor magnitude; set the quotient bit if the result is non-negative.
  - After iteration CYCLES-1 (counter==31), go to FINISH.
- FINISH (one cycle): apply the sign fix and write `result`; pulse `done`=1 for exactly one cycle; go to IDLE.
- Latency: `start` accepted at edge k → `done` high in the cycle following edge k+33. Latency is fixed for all codes, including special cases.
- Signedness:
  - MUL and MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU and REMU: unsigned.
  - DIV and REM: signed.
- Result selection:
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
  - The product is negated over 64 bits when the operand signs differ (considering only signed operands).
  - Quotient is negated when sign(a)≠sign(b) for DIV.
  - Remainder takes the sign of the dividend for REM.
- Divide by zero (b==0), checked in FINISH:
  - DIV and DIVU return 0xFFFFFFFF.
  - REM and REMU return operand_a.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV returns 0x80000000 and REM returns 0.
- Non-M `alu_function` code: accepted with normal latency; result=0.
- `start` while `busy`: ignored. Latched operands and function are unchanged.
- `start` in the FINISH cycle: ignored. It is accepted from the next cycle (IDLE).
- `flush`:
  - In CALC or FINISH: next state IDLE; busy=0; no `done`; `result` keeps its old value.
  - `flush` has priority over `start` in the same cycle.
- `reset_n` low mid-operation: immediate return to reset values; no `done` after release.
- Operand inputs may change freely after the accept cycle.

Test Plan:
- MUL 0x00000007 × 0xFFFFFFFD → `done` exactly 34 cycles after the start cycle, result=0xFFFFFFEB, busy high for 33 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM → 0xFFFFFFFF. DIVU 100/7 → 14. REMU → 2.
- Specials:
  - DIVU 0x12345678/0 → 0xFFFFFFFF; REMU → 0x12345678.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Second `start` with different operands at cycle 10 of a MUL → ignored; the first result is delivered once and no second `done` occurs.
- Abort cases:
  - `flush` at cycle 15 of a DIV → busy=0 next cycle, no `done`, result unchanged. A new start then completes normally.
  - `reset_n` pulsed low at cycle 20 → busy=0, done=0 and result=0 immediately.
